// File: rtl/mem_ddr_access.sv
// mem_ddr_access: load/store sequencer between the Memory stage and the DDR3 controller.
// One request in flight; read beats are captured through a two-flop pipeline.
module mem_ddr_access #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [28:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  input  logic        ddr_cmd_rdy_i,
  input  logic        ddr_wdata_rdy_i,
  input  logic [31:0] ddr_read_data_i,
  input  logic        ddr_read_data_valid_i,
  input  logic        ddr_read_data_end_i,
  output logic        ddr_enable_o,
  output logic        ddr_cmd_o,
  output logic [28:0] ddr_addr_o,
  output logic [31:0] ddr_wdata_o,
  output logic [3:0]  ddr_wdata_mask_o,
  output logic        ddr_wdata_en_o,
  output logic        ddr_wdata_end_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        vld_r_q, vld_rr_q;
  logic        end_r_q, end_rr_q;
  logic [31:0] dat_r_q, dat_rr_q;
  logic [31:0] word_q;
  logic        first_q;
  logic [CW-1:0] cnt_q;

  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_data_q;
  logic        en_q, cmd_q, wen_q;
  logic [28:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  logic        req_err_d;
  logic [31:0] wdata_d;
  logic [3:0]  mask_d;
  logic [31:0] beat_d;
  logic [15:0] half_d;
  logic [7:0]  byte_d;
  logic [31:0] load_d;

  assign req_err_d = (req_size_i == 2'b11)
                   | ((req_size_i == 2'b01) & req_addr_i[0])
                   | ((req_size_i == 2'b10) & (|req_addr_i[1:0]));

  always_comb begin
    wdata_d = req_wdata_i;
    mask_d  = 4'b0000;
    unique case (req_size_i)
      2'b00: begin
        wdata_d = {4{req_wdata_i[7:0]}};
        mask_d  = ~(4'b0001 << req_addr_i[1:0]);
      end
      2'b01: begin
        wdata_d = {2{req_wdata_i[15:0]}};
        mask_d  = req_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  // A lone end beat is both first and last, so take it straight from the pipe.
  assign beat_d = first_q ? word_q : dat_rr_q;
  assign half_d = lane_q[1] ? beat_d[31:16] : beat_d[15:0];
  assign byte_d = lane_q[0] ? half_d[15:8] : half_d[7:0];

  always_comb begin
    load_d = beat_d;
    unique case (size_q)
      2'b00:   load_d = {{24{byte_d[7] & ~uns_q}}, byte_d};
      2'b01:   load_d = {{16{half_d[15] & ~uns_q}}, half_d};
      default: load_d = beat_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      vld_r_q     <= 1'b0;
      vld_rr_q    <= 1'b0;
      end_r_q     <= 1'b0;
      end_rr_q    <= 1'b0;
      dat_r_q     <= '0;
      dat_rr_q    <= '0;
      word_q      <= '0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      en_q        <= 1'b0;
      cmd_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
    end else begin
      vld_r_q     <= ddr_read_data_valid_i;
      vld_rr_q    <= vld_r_q;
      end_r_q     <= ddr_read_data_end_i;
      end_rr_q    <= end_r_q;
      dat_r_q     <= ddr_read_data_i;
      dat_rr_q    <= dat_r_q;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            lane_q <= req_addr_i[1:0];
            size_q <= req_size_i;
            uns_q  <= req_unsigned_i;
            if (req_err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              addr_q <= {req_addr_i[28:2], 2'b00};
              if (req_write_i) begin
                state_q <= WR_DATA;
                wdata_q <= wdata_d;
                mask_q  <= mask_d;
                wen_q   <= 1'b1;
              end else begin
                state_q <= RD_CMD;
                en_q    <= 1'b1;
                cmd_q   <= 1'b0;
              end
            end
          end
        end
        WR_DATA: begin
          if (ddr_wdata_rdy_i) begin
            state_q <= WR_CMD;
            wen_q   <= 1'b0;
            en_q    <= 1'b1;
            cmd_q   <= 1'b1;
          end
        end
        WR_CMD: begin
          if (ddr_cmd_rdy_i) begin
            state_q     <= RESP;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        RD_CMD: begin
          if (ddr_cmd_rdy_i) begin
            state_q <= RD_WAIT;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (vld_rr_q && !first_q) begin
            word_q  <= dat_rr_q;
            first_q <= 1'b1;
          end
          if (vld_rr_q && end_rr_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= load_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_data_o       = rsp_data_q;
  assign ddr_enable_o     = en_q;
  assign ddr_cmd_o        = cmd_q;
  assign ddr_addr_o       = addr_q;
  assign ddr_wdata_o      = wdata_q;
  assign ddr_wdata_mask_o = mask_q;
  assign ddr_wdata_en_o   = wen_q;
  assign ddr_wdata_end_o  = wen_q;

endmodule

// File: tb/tb_mem_ddr_access.sv
// tb_mem_ddr_access: vector table, hand sequences and random traffic
// for mem_ddr_access against a byte-lane reference model.
module tb_mem_ddr_access;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [28:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic        ddr_cmd_rdy_i, ddr_wdata_rdy_i;
  logic [31:0] ddr_read_data_i;
  logic        ddr_read_data_valid_i, ddr_read_data_end_i;
  logic        ddr_enable_o, ddr_cmd_o, ddr_wdata_en_o, ddr_wdata_end_o;
  logic [28:0] ddr_addr_o;
  logic [31:0] ddr_wdata_o;
  logic [3:0]  ddr_wdata_mask_o;

  int checks = 0;
  int failures = 0;

  mem_ddr_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .ddr_cmd_rdy_i(ddr_cmd_rdy_i), .ddr_wdata_rdy_i(ddr_wdata_rdy_i),
    .ddr_read_data_i(ddr_read_data_i),
    .ddr_read_data_valid_i(ddr_read_data_valid_i),
    .ddr_read_data_end_i(ddr_read_data_end_i),
    .ddr_enable_o(ddr_enable_o), .ddr_cmd_o(ddr_cmd_o),
    .ddr_addr_o(ddr_addr_o), .ddr_wdata_o(ddr_wdata_o),
    .ddr_wdata_mask_o(ddr_wdata_mask_o),
    .ddr_wdata_en_o(ddr_wdata_en_o), .ddr_wdata_end_o(ddr_wdata_end_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [28:0] addr;
    logic [31:0] wdata;
    int          wdly, cdly, ddly, nb;
    logic [31:0] beat0, beat1;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [31:0] exp_wd;
    logic [3:0]  exp_mk;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err, bad, touched, post_valid, post_ready;
  } res_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic m_misalign(input logic [1:0] sz, input logic [28:0] a);
    int n;
    n = 1 << sz;
    return (sz == 2'd3) || ((int'(a % 29'd4) % n) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [28:0] a, input logic [31:0] w);
    int bits, off;
    logic [31:0] keep, v;
    if (sz == 2'd2) return w;
    bits = (sz == 2'd0) ? 8 : 16;
    off  = int'(a % 29'd4);
    keep = (32'h1 << bits) - 32'h1;
    v    = (w >> (8 * off)) & keep;
    if (!uns && v[bits-1]) v = v | ~keep;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    int n;
    logic [31:0] r;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [28:0] a);
    int n, off;
    logic [3:0] r;
    n = 1 << sz;
    off = int'(a % 29'd4);
    for (int i = 0; i < 4; i++) r[i] = !(i >= off && i < off + n);
    return r;
  endfunction

  function automatic void m_resp(input vec_t v, output logic err,
                                 output logic [31:0] d, output int lat);
    err = m_misalign(v.size, v.addr);
    d = 32'h0;
    lat = 1;
    if (!err) begin
      if (v.wr) lat = 3 + v.wdly + v.cdly;
      else if (v.nb == 0) begin
        err = 1'b1;
        lat = v.cdly + 2 + TMO;
      end else begin
        d = m_load(v.size, v.uns, v.addr, v.beat0);
        lat = v.cdly + v.ddly + v.nb + 4;
      end
    end
  endfunction

  // Drives one request and plays the DDR side with the vector's delays.
  task automatic run_req(input vec_t v, output res_t r);
    int acc, wc, cc, k;
    logic [31:0] ewd;
    logic [3:0]  emk;
    logic [28:0] eaddr;
    ewd = m_wdata(v.size, v.wdata);
    emk = m_mask(v.size, v.addr);
    eaddr = v.addr & ~29'h3;
    r.lat = 0; r.data = '0; r.err = 1'b0; r.bad = 1'b0; r.touched = 1'b0;
    acc = -100; wc = 0; cc = 0;
    if (req_ready_o !== 1'b1) r.bad = 1'b1;
    req_valid_i = 1'b1; req_write_i = v.wr; req_size_i = v.size;
    req_unsigned_i = v.uns; req_addr_i = v.addr; req_wdata_i = v.wdata;
    tick();
    req_valid_i = 1'b0;
    req_wdata_i = $urandom;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (ddr_wdata_en_o) begin
        r.touched = 1'b1;
        if (ddr_wdata_o !== ewd || ddr_wdata_mask_o !== emk || ddr_wdata_end_o !== 1'b1)
          r.bad = 1'b1;
      end else if (ddr_wdata_end_o !== 1'b0) r.bad = 1'b1;
      if (ddr_enable_o) begin
        r.touched = 1'b1;
        if (ddr_addr_o !== eaddr || ddr_cmd_o !== v.wr) r.bad = 1'b1;
      end
      if (req_ready_o !== 1'b0) r.bad = 1'b1;
      if (rsp_valid_o) begin
        r.lat = cyc; r.data = rsp_data_o; r.err = rsp_err_o;
        break;
      end
      k = cyc - (acc + 1 + v.ddly);
      if (k >= 0 && k < v.nb) begin
        ddr_read_data_valid_i = 1'b1;
        ddr_read_data_i = (k == 0) ? v.beat0 : v.beat1;
        ddr_read_data_end_i = (k == v.nb - 1);
      end else begin
        ddr_read_data_valid_i = 1'b0;
        ddr_read_data_i = $urandom;
        ddr_read_data_end_i = 1'($urandom);
      end
      ddr_wdata_rdy_i = ddr_wdata_en_o ? (wc >= v.wdly) : 1'($urandom);
      if (ddr_wdata_en_o) wc++;
      ddr_cmd_rdy_i = ddr_enable_o ? (cc >= v.cdly) : 1'($urandom);
      if (ddr_enable_o) cc++;
      if (ddr_enable_o && ddr_cmd_rdy_i && !ddr_cmd_o) acc = cyc;
      tick();
    end
    ddr_read_data_valid_i = 1'b0; ddr_read_data_end_i = 1'b0;
    ddr_wdata_rdy_i = 1'b0; ddr_cmd_rdy_i = 1'b0;
    tick();
    r.post_valid = rsp_valid_o;
    r.post_ready = req_ready_o;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input res_t r,
                           input logic ee, input logic [31:0] ed, input int el,
                           input logic [31:0] ewd, input logic [3:0] emk);
    chk({tag, "_lat"}, 32'(r.lat), 32'(el));
    chk({tag, "_err"}, 32'(r.err), 32'(ee));
    chk({tag, "_data"}, r.data, ed);
    chk({tag, "_strobes"}, 32'(r.bad), 32'h0);
    chk({tag, "_ddr_touch"}, 32'(r.touched), 32'(el != 1));
    chk({tag, "_post"}, 32'({r.post_valid, r.post_ready}), 32'h1);
    if (!ee && v.wr) begin
      chk({tag, "_wdata"}, ddr_wdata_o, ewd);
      chk({tag, "_mask"}, 32'(ddr_wdata_mask_o), 32'(emk));
    end
    if (!ee && !v.wr) chk({tag, "_addr"}, 32'(ddr_addr_o), 32'(v.addr & ~29'h3));
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'h0);
    chk({tag, "_rsp_data"}, rsp_data_o, 32'h0);
    chk({tag, "_strobes"}, 32'({ddr_enable_o, ddr_cmd_o, ddr_wdata_en_o, ddr_wdata_end_o}), 32'h0);
    chk({tag, "_addr"}, 32'(ddr_addr_o), 32'h0);
    chk({tag, "_wdata"}, ddr_wdata_o, 32'h0);
    chk({tag, "_mask"}, 32'(ddr_wdata_mask_o), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    vec_t v;
    logic ee, saw;
    logic [31:0] ed;
    int el;

    vecs[0]  = '{0, 2'd0, 0, 29'h3, 32'h0, 0, 0, 0, 1, 32'h80FF1234, 32'h0, 0, 32'hFFFFFF80, 5, 32'h0, 4'h0};
    vecs[1]  = '{0, 2'd1, 1, 29'h2, 32'h0, 0, 2, 1, 1, 32'h80017FFF, 32'h0, 0, 32'h00008001, 8, 32'h0, 4'h0};
    vecs[2]  = '{0, 2'd1, 0, 29'h2, 32'h0, 0, 0, 0, 1, 32'h80017FFF, 32'h0, 0, 32'hFFFF8001, 5, 32'h0, 4'h0};
    vecs[3]  = '{1, 2'd0, 0, 29'h5, 32'h000000A5, 4, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 7, 32'hA5A5A5A5, 4'b1101};
    vecs[4]  = '{0, 2'd2, 0, 29'h6, 32'h0, 0, 0, 0, 1, 32'h12345678, 32'h0, 1, 32'h0, 1, 32'h0, 4'h0};
    vecs[5]  = '{0, 2'd3, 0, 29'h0, 32'h0, 0, 0, 0, 1, 32'h12345678, 32'h0, 1, 32'h0, 1, 32'h0, 4'h0};
    vecs[6]  = '{1, 2'd1, 0, 29'h3, 32'h1234, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 1, 32'h0, 4'h0};
    vecs[7]  = '{0, 2'd2, 0, 29'h8, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 32'h0, 11, 32'h0, 4'h0};
    vecs[8]  = '{1, 2'd2, 0, 29'hC, 32'h12345678, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 3, 32'h12345678, 4'b0000};
    vecs[9]  = '{1, 2'd1, 0, 29'h6, 32'hBEEFCAFE, 1, 2, 0, 0, 32'h0, 32'h0, 0, 32'h0, 6, 32'hCAFECAFE, 4'b0011};
    vecs[10] = '{0, 2'd2, 0, 29'h4, 32'h0, 0, 0, 1, 2, 32'h11223344, 32'h55667788, 0, 32'h11223344, 7, 32'h0, 4'h0};
    vecs[11] = '{0, 2'd0, 1, 29'h1, 32'h0, 0, 0, 0, 1, 32'h00009A00, 32'h0, 0, 32'h0000009A, 5, 32'h0, 4'h0};
    vecs[12] = '{0, 2'd1, 0, 29'h1FFFFFFE, 32'h0, 0, 0, 3, 1, 32'h7FFF0000, 32'h0, 0, 32'h00007FFF, 8, 32'h0, 4'h0};

    rst = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0;
    ddr_cmd_rdy_i = 1'b0; ddr_wdata_rdy_i = 1'b0; ddr_read_data_i = '0;
    ddr_read_data_valid_i = 1'b0; ddr_read_data_end_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid_i = 1'b1; req_size_i = 2'd2; req_addr_i = 29'h40;
    tick();
    chk_all_reset("reset");
    req_valid_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("reset_release_idle", 32'({req_ready_o, ddr_enable_o}), 32'h2);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], r);
      check_txn($sformatf("vec%0d", i), vecs[i], r, vecs[i].exp_err, vecs[i].exp_data,
                vecs[i].exp_lat, vecs[i].exp_wd, vecs[i].exp_mk);
    end

    // Late beat after a timeout must be dropped.
    run_req(vecs[7], r);
    chk("late_tmo_err", 32'({r.err, 32'(r.lat)}), 32'({1'b1, 32'd11}));
    ddr_read_data_valid_i = 1'b1; ddr_read_data_end_i = 1'b1; ddr_read_data_i = 32'hDEADBEEF;
    tick();
    ddr_read_data_valid_i = 1'b0; ddr_read_data_end_i = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      if (rsp_valid_o || !req_ready_o) saw = 1'b1;
      tick();
    end
    chk("late_beat_ignored", 32'(saw), 32'h0);
    run_req(vecs[2], r);
    check_txn("late_next", vecs[2], r, 1'b0, 32'hFFFF8001, 5, 32'h0, 4'h0);

    // Reset in RD_WAIT.
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'd2; req_addr_i = 29'h10;
    tick();
    req_valid_i = 1'b0;
    ddr_cmd_rdy_i = 1'b1;
    tick();
    ddr_cmd_rdy_i = 1'b0;
    tick();
    tick();
    chk("rstmid_pre_addr", 32'(ddr_addr_o), 32'h10);
    #2 rst = 1'b1;
    #1;
    chk_all_reset("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ddr_read_data_valid_i = 1'b1; ddr_read_data_end_i = 1'b1; ddr_read_data_i = 32'h0BADF00D;
    tick();
    ddr_read_data_valid_i = 1'b0; ddr_read_data_end_i = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      if (rsp_valid_o || ddr_enable_o || !req_ready_o) saw = 1'b1;
      tick();
    end
    chk("rstmid_no_rsp", 32'(saw), 32'h0);
    run_req(vecs[0], r);
    check_txn("rstmid_next", vecs[0], r, 1'b0, 32'hFFFFFF80, 5, 32'h0, 4'h0);

    for (int n = 0; n < 80; n++) begin
      v.wr = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
      v.addr = 29'($urandom); v.wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (v.size == 2'd1) v.addr[0] = 1'b0;
        if (v.size == 2'd2) v.addr[1:0] = 2'b00;
      end
      v.wdly = int'($urandom_range(0, 3));
      v.cdly = int'($urandom_range(0, 3));
      v.ddly = int'($urandom_range(0, 3));
      v.nb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2));
      v.beat0 = $urandom; v.beat1 = $urandom;
      m_resp(v, ee, ed, el);
      run_req(v, r);
      check_txn($sformatf("rnd%0d", n), v, r, ee, ed, el,
                m_wdata(v.size, v.wdata), m_mask(v.size, v.addr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ddr_access.md
# mem_ddr_access

Load/store access sequencer sitting directly downstream of the Memory pipeline stage and upstream of the DDR3 controller IP. Accepts one byte/halfword/word request at a time and performs the alignment check. Drives the DDR3 application command and write-data handshakes, and receives read data through a two-flop capture pipeline. Returns lane-extracted, sign/zero-extended load data (or store completion) as a single-cycle response.

## Interface
- TIMEOUT, 1023: max cycles in RD_WAIT before an error response.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present from Memory stage.
- req_ready_o  out  1  block can accept; equals (state==IDLE).
- req_write_i  in  1  1 store, 0 load.
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr_i  in  29  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  32  load result; 0 for stores and errors.
- rsp_err_o  out  1  qualifies rsp_valid_o: misaligned, reserved size or timeout.
- ddr_cmd_rdy_i  in  1  IP accepts command.
- ddr_wdata_rdy_i  in  1  IP accepts write data.
- ddr_read_data_i  in  32  read beat.
- ddr_read_data_valid_i  in  1  read beat valid.
- ddr_read_data_end_i  in  1  last beat of burst.
- ddr_enable_o  out  1  command valid.
- ddr_cmd_o  out  1  0 read, 1 write.
- ddr_addr_o  out  29  {addr[28:2],2'b00}.
- ddr_wdata_o  out  32  lane-replicated store data.
- ddr_wdata_mask_o  out  4  1 = byte NOT written.
- ddr_wdata_en_o  out  1  write data valid.
- ddr_wdata_end_o  out  1  equals ddr_wdata_en_o (single beat).

## Operation
- States: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, RESP.
- IDLE: on req_valid_i, register addr/size/unsigned/wdata/write. Error check: size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 → RESP with err=1, no DDR activity. Otherwise store → WR_DATA, load → RD_CMD.
- WR_DATA: ddr_wdata_en_o=1. Byte: data {4{b}}, mask ~(4'b0001<<addr[1:0]). Halfword: {2{h}}, mask addr[1]?4'b0011:4'b1100. Word: mask 0000. Leave on ddr_wdata_rdy_i → WR_CMD.
- WR_CMD: ddr_enable_o=1, ddr_cmd_o=1; on ddr_cmd_rdy_i → RESP (err=0, data=0).
- RD_CMD: ddr_enable_o=1, ddr_cmd_o=0; on ddr_cmd_rdy_i → RD_WAIT, timeout counter cleared.
- Capture pipeline: valid/data/end registered twice every cycle (_r, _rr), regardless of state.
- RD_WAIT: first valid_rr beat latched as load word. Move to RESP when a valid_rr beat with end_rr=1 arrives; a single beat with end=1 is both first and last. Counter increments per cycle; reaching TIMEOUT → RESP, err=1, data=0.
- Extraction: byte lane addr[1:0]; halfword lane addr[1]; 8/16-bit result extended per req_unsigned_i.
- RESP: rsp_valid_o=1 for exactly one cycle → IDLE.
- Beats arriving outside RD_WAIT (late data after timeout) are discarded.
- Outputs hold their values between transactions except valid/enable strobes.

## Timing
- Reset values: state IDLE, req_ready_o=1 (requests ignored while rst high), rsp_valid_o/rsp_err_o/ddr_enable_o/ddr_wdata_en_o/ddr_wdata_end_o/ddr_cmd_o=0, all data/address/mask outputs 0, capture pipeline and counter 0.
- Reset mid-transaction: strobes drop asynchronously; no response issued.
- Accept at cycle T; first DDR strobe asserted at T+1.
- Error request: rsp_valid_o at T+1.
- Read: cmd_rdy in cycle C; beat with end valid at input in cycle D → rsp_valid_o high in cycle D+3; req_ready_o high at D+4.
- Store with wdata_rdy and cmd_rdy immediate: rsp_valid_o at T+3.
- Strobes held indefinitely while the corresponding rdy is low; address/data stable while held.

## Test plan
- Load byte addr 0x0000003, beat 0x80FF_1234, signed → rsp_data 0xFFFF_FF80, err 0, ddr_addr 0x0000000, rsp at D+3.
- Load halfword addr 0x2, unsigned, beat 0x8001_7FFF → 0x0000_8001; same signed → 0xFFFF_8001.
- Store byte 0xA5 to addr 0x5 with ddr_wdata_rdy_i low 4 cycles → wdata 0xA5A5_A5A5, mask 4'b1101 held 4 cycles, then command, rsp at accept+7.
- Word load addr 0x6 → rsp err=1 at T+1, no ddr_enable_o; size 11 likewise.
- Read with no data, TIMEOUT=8 → err response after 8 RD_WAIT cycles; late beat then ignored, next load correct.
- Assert rst during RD_WAIT → all outputs reset immediately, no rsp_valid_o, next request completes normally.
